// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types and constants.
//   VGA_CNT_W       width of every counter and mode field
//   vga_cfg_t       runtime mode: active/front porch/sync/back porch, h then v
//   VGA_CFG_800x600 power-on mode of vga_timing_cfg
//   vga_cfg_check   1 when a mode is usable by the timing generator
// The fixed 640x480 constants remain for the older fixed-mode controller.
package vga_pkg;

    localparam int VGA_CNT_W = 11;

    // Legacy fixed-mode 640x480 timing.
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] h_act;
        logic [VGA_CNT_W-1:0] h_fp;
        logic [VGA_CNT_W-1:0] h_sync;
        logic [VGA_CNT_W-1:0] h_bp;
        logic [VGA_CNT_W-1:0] v_act;
        logic [VGA_CNT_W-1:0] v_fp;
        logic [VGA_CNT_W-1:0] v_sync;
        logic [VGA_CNT_W-1:0] v_bp;
    } vga_cfg_t;

    localparam vga_cfg_t VGA_CFG_800x600 = '{
        h_act:  VGA_CNT_W'(800), h_fp: VGA_CNT_W'(40), h_sync: VGA_CNT_W'(128), h_bp: VGA_CNT_W'(88),
        v_act:  VGA_CNT_W'(600), v_fp: VGA_CNT_W'(1),  v_sync: VGA_CNT_W'(4),   v_bp: VGA_CNT_W'(23)
    };

    // A mode is usable when no field is zero and each total fits the counters.
    // Totals are formed two bits wider so four maximal fields cannot overflow.
    function automatic bit vga_cfg_check(vga_cfg_t c);
        logic [VGA_CNT_W+1:0] h_tot;
        logic [VGA_CNT_W+1:0] v_tot;
        logic [VGA_CNT_W+1:0] span;
        bit                   nz;
        span  = {2'b01, {VGA_CNT_W{1'b0}}};
        h_tot = {2'b00, c.h_act} + {2'b00, c.h_fp} + {2'b00, c.h_sync} + {2'b00, c.h_bp};
        v_tot = {2'b00, c.v_act} + {2'b00, c.v_fp} + {2'b00, c.v_sync} + {2'b00, c.v_bp};
        nz    = (c.h_act != '0) && (c.h_fp != '0) && (c.h_sync != '0) && (c.h_bp != '0) &&
                (c.v_act != '0) && (c.v_fp != '0) && (c.v_sync != '0) && (c.v_bp != '0);
        return nz && (h_tot <= span) && (v_tot <= span);
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: raster bus from the timing generator to the draw stages.
//   hcount/vcount  current pixel position
//   hsync/vsync    sync outputs at the configured polarity
//   hblnk/vblnk    high outside the active area
interface vga_if #(
    parameter int CNT_W = 11
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;

    modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk);
    modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);
endinterface

// File: rtl/vga_cfg_shadow.sv
// vga_cfg_shadow: holds the active mode (cur) and one pending mode (pend).
//   cfg_in/cfg_valid/cfg_ready  mode request handshake
//   cfg_err                     one-cycle pulse for a rejected request
//   cfg_pending                 a mode is waiting for the frame boundary
//   wrap_en                     counters step past the last pixel of the frame now
//   cur                         mode in force for the current count
//   cur_nxt                     mode in force for the count being loaded this edge
module vga_cfg_shadow
    import vga_pkg::*;
#(
    parameter vga_cfg_t DEF_CFG = VGA_CFG_800x600
) (
    input  logic     clk,
    input  logic     rst,
    input  vga_cfg_t cfg_in,
    input  logic     cfg_valid,
    input  logic     wrap_en,
    output logic     cfg_ready,
    output logic     cfg_err,
    output logic     cfg_pending,
    output vga_cfg_t cur,
    output vga_cfg_t cur_nxt
);
    vga_cfg_t cur_q, cur_d;
    vga_cfg_t pend_q, pend_d;
    logic     pending_q, pending_d;
    logic     err_q, err_d;

    // Handshake: a request transfers on a cycle with cfg_valid && cfg_ready.
    // cfg_ready is simply "nothing pending", so a transfer and an apply can
    // never coincide; cfg_valid while not ready is dropped silently.
    always_comb begin
        cur_d     = cur_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        if (cfg_valid && !pending_q) begin
            if (vga_cfg_check(cfg_in)) begin
                pend_d    = cfg_in;
                pending_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (wrap_en && pending_q) begin
            cur_d     = pend_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q     <= DEF_CFG;
            pend_q    <= DEF_CFG;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign cfg_ready   = !pending_q;
    assign cfg_err     = err_q;
    assign cfg_pending = pending_q;
    assign cur         = cur_q;
    // The frame that starts at a wrap must already decode with the new mode.
    assign cur_nxt     = cur_d;
endmodule

// File: rtl/vga_timing_cfg.sv
// vga_timing_cfg: runtime-reconfigurable VGA timing generator.
//   clk, rst (sync, active-high), pix_en (advance enable)
//   cfg_in/cfg_valid/cfg_ready/cfg_err/cfg_pending  mode update port
//   frame_start/line_start  one-cycle strobes coinciding with (0,0) / hcount==0
//   de   active-area enable, registered with the bus
//   vio  hcount/vcount/hsync/hblnk/vsync/vblnk
// CNT_W must equal vga_pkg::VGA_CNT_W and the width of the vio interface.
module vga_timing_cfg
    import vga_pkg::*;
#(
    parameter int       CNT_W   = 11,
    parameter bit       H_POL   = 1'b1,
    parameter bit       V_POL   = 1'b1,
    parameter vga_cfg_t DEF_CFG = VGA_CFG_800x600
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pix_en,
    input  vga_cfg_t cfg_in,
    input  logic     cfg_valid,
    output logic     cfg_ready,
    output logic     cfg_err,
    output logic     cfg_pending,
    output logic     frame_start,
    output logic     line_start,
    output logic     de,
    vga_if.out       vio
);
    localparam int SW = CNT_W + 2;

    vga_cfg_t      cur, cur_nxt;
    logic [SW-1:0] h_tot, v_tot;
    logic [SW-1:0] hs_str_n, hs_stp_n, vs_str_n, vs_stp_n;
    logic          h_last, v_last, wrap_en;

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic hsync_q, hsync_d, hblnk_q, hblnk_d;
    logic vsync_q, vsync_d, vblnk_q, vblnk_d;
    logic de_q, de_d, frame_start_q, frame_start_d, line_start_q, line_start_d;

    function automatic logic [SW-1:0] ext(input logic [CNT_W-1:0] x);
        return {2'b00, x};
    endfunction

    // Wrap points come from the mode in force for the current count.
    assign h_tot   = ext(cur.h_act) + ext(cur.h_fp) + ext(cur.h_sync) + ext(cur.h_bp);
    assign v_tot   = ext(cur.v_act) + ext(cur.v_fp) + ext(cur.v_sync) + ext(cur.v_bp);
    assign h_last  = (ext(hcount_q) == h_tot - SW'(1));
    assign v_last  = (ext(vcount_q) == v_tot - SW'(1));
    assign wrap_en = pix_en && h_last && v_last;

    // Sync windows come from the mode in force for the next count.
    assign hs_str_n = ext(cur_nxt.h_act) + ext(cur_nxt.h_fp);
    assign hs_stp_n = hs_str_n + ext(cur_nxt.h_sync);
    assign vs_str_n = ext(cur_nxt.v_act) + ext(cur_nxt.v_fp);
    assign vs_stp_n = vs_str_n + ext(cur_nxt.v_sync);

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hsync_d       = hsync_q;
        hblnk_d       = hblnk_q;
        vsync_d       = vsync_q;
        vblnk_d       = vblnk_q;
        de_d          = de_q;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        if (pix_en) begin
            hcount_d      = h_last ? '0 : hcount_q + CNT_W'(1);
            vcount_d      = !h_last ? vcount_q : (v_last ? '0 : vcount_q + CNT_W'(1));
            line_start_d  = h_last;
            frame_start_d = h_last && v_last;
            // Flags decode the count being loaded so they line up with it.
            hblnk_d = ext(hcount_d) >= ext(cur_nxt.h_act);
            vblnk_d = ext(vcount_d) >= ext(cur_nxt.v_act);
            hsync_d = ((ext(hcount_d) >= hs_str_n) && (ext(hcount_d) < hs_stp_n)) ? H_POL : !H_POL;
            vsync_d = ((ext(vcount_d) >= vs_str_n) && (ext(vcount_d) < vs_stp_n)) ? V_POL : !V_POL;
            de_d    = !hblnk_d && !vblnk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= !H_POL;
            hblnk_q       <= 1'b0;
            vsync_q       <= !V_POL;
            vblnk_q       <= 1'b0;
            de_q          <= 1'b1;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            hblnk_q       <= hblnk_d;
            vsync_q       <= vsync_d;
            vblnk_q       <= vblnk_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    vga_cfg_shadow #(
        .DEF_CFG (DEF_CFG)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .cfg_in      (cfg_in),
        .cfg_valid   (cfg_valid),
        .wrap_en     (wrap_en),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .cfg_pending (cfg_pending),
        .cur         (cur),
        .cur_nxt     (cur_nxt)
    );

    assign vio.hcount  = hcount_q;
    assign vio.vcount  = vcount_q;
    assign vio.hsync   = hsync_q;
    assign vio.hblnk   = hblnk_q;
    assign vio.vsync   = vsync_q;
    assign vio.vblnk   = vblnk_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
endmodule

// File: tb/tb_vga_timing_cfg.sv
// tb_vga_timing_cfg: two generators side by side.
//   dut_a: default 800x600, active-high syncs (line-level timing, long-pending request).
//   dut_b: tiny 15x8 default mode, active-low syncs (frame-level behaviour and mode switches).
// A reference model predicts every bus/strobe/handshake output each cycle.
module tb_vga_timing_cfg;
    import vga_pkg::*;

    logic     clk = 1'b0;
    logic     rst, pix_en;
    vga_cfg_t cfg_in_a, cfg_in_b;
    logic     cfg_valid_a, cfg_valid_b;
    logic     rdy_a, err_a, pend_a, fs_a, ls_a, de_a;
    logic     rdy_b, err_b, pend_b, fs_b, ls_b, de_b;

    vga_if #(.CNT_W(11)) vio_a ();
    vga_if #(.CNT_W(11)) vio_b ();

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        int       h;
        int       v;
        vga_cfg_t cur;
        vga_cfg_t pend;
        vga_cfg_t def;
        bit       pending;
        bit       fs;
        bit       ls;
        bit       err;
        bit       hpol;
        bit       vpol;
    } mdl_t;

    mdl_t ma, mb;
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    vga_cfg_t cfg_b0, cfg_b1, cfg_b2, cfg_640, bad1, bad2;

    function automatic vga_cfg_t mk_cfg(input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb);
        vga_cfg_t c;
        c.h_act = VGA_CNT_W'(ha); c.h_fp = VGA_CNT_W'(hf); c.h_sync = VGA_CNT_W'(hs); c.h_bp = VGA_CNT_W'(hb);
        c.v_act = VGA_CNT_W'(va); c.v_fp = VGA_CNT_W'(vf); c.v_sync = VGA_CNT_W'(vs); c.v_bp = VGA_CNT_W'(vb);
        return c;
    endfunction

    function automatic int tot_h(vga_cfg_t c);
        return int'(c.h_act) + int'(c.h_fp) + int'(c.h_sync) + int'(c.h_bp);
    endfunction

    function automatic int tot_v(vga_cfg_t c);
        return int'(c.v_act) + int'(c.v_fp) + int'(c.v_sync) + int'(c.v_bp);
    endfunction

    function automatic bit cfg_ok(vga_cfg_t c);
        bit nz;
        nz = c.h_act != 0 && c.h_fp != 0 && c.h_sync != 0 && c.h_bp != 0 &&
             c.v_act != 0 && c.v_fp != 0 && c.v_sync != 0 && c.v_bp != 0;
        return nz && tot_h(c) <= 2048 && tot_v(c) <= 2048;
    endfunction

    function automatic mdl_t mdl_init(vga_cfg_t d, bit hp, bit vp);
        mdl_t m;
        m.h = 0; m.v = 0; m.cur = d; m.pend = d; m.def = d;
        m.pending = 0; m.fs = 0; m.ls = 0; m.err = 0; m.hpol = hp; m.vpol = vp;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, bit r, bit pe, bit cv, vga_cfg_t ci);
        mdl_t n;
        bit   line_end, frame_end;
        n = m;
        n.fs = 0; n.ls = 0; n.err = 0;
        if (r) begin
            n.h = 0; n.v = 0; n.cur = m.def; n.pending = 0;
            return n;
        end
        line_end  = pe && (m.h == tot_h(m.cur) - 1);
        frame_end = line_end && (m.v == tot_v(m.cur) - 1);
        if (cv && !m.pending) begin
            if (cfg_ok(ci)) begin n.pend = ci; n.pending = 1; end
            else n.err = 1;
        end
        if (frame_end && m.pending) begin n.cur = m.pend; n.pending = 0; end
        if (pe) begin
            n.fs = frame_end;
            n.ls = line_end;
            if (line_end) begin n.h = 0; n.v = frame_end ? 0 : m.v + 1; end
            else n.h = m.h + 1;
        end
        return n;
    endfunction

    // {hcount, vcount, hsync, hblnk, vsync, vblnk, de, frame_start, line_start, ready, err, pending}
    function automatic logic [31:0] mdl_out(mdl_t m);
        int ha, hs0, hs1, va, vs0, vs1;
        bit hb, vb, hs, vs;
        ha = int'(m.cur.h_act); hs0 = ha + int'(m.cur.h_fp); hs1 = hs0 + int'(m.cur.h_sync);
        va = int'(m.cur.v_act); vs0 = va + int'(m.cur.v_fp); vs1 = vs0 + int'(m.cur.v_sync);
        hb = m.h >= ha;
        vb = m.v >= va;
        hs = (m.h >= hs0 && m.h < hs1) ? m.hpol : !m.hpol;
        vs = (m.v >= vs0 && m.v < vs1) ? m.vpol : !m.vpol;
        return {VGA_CNT_W'(m.h), VGA_CNT_W'(m.v), hs, hb, vs, vb, (!hb && !vb),
                m.fs, m.ls, !m.pending, m.err, m.pending};
    endfunction

    // ---------------- DUTs ----------------
    vga_timing_cfg #(
        .CNT_W(11), .H_POL(1'b1), .V_POL(1'b1), .DEF_CFG(VGA_CFG_800x600)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cfg_in(cfg_in_a), .cfg_valid(cfg_valid_a),
        .cfg_ready(rdy_a), .cfg_err(err_a), .cfg_pending(pend_a), .frame_start(fs_a),
        .line_start(ls_a), .de(de_a), .vio(vio_a.out)
    );

    vga_timing_cfg #(
        .CNT_W(11), .H_POL(1'b0), .V_POL(1'b0),
        .DEF_CFG('{h_act: 11'd8, h_fp: 11'd2, h_sync: 11'd3, h_bp: 11'd2,
                   v_act: 11'd4, v_fp: 11'd1, v_sync: 11'd2, v_bp: 11'd1})
    ) dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cfg_in(cfg_in_b), .cfg_valid(cfg_valid_b),
        .cfg_ready(rdy_b), .cfg_err(err_b), .cfg_pending(pend_b), .frame_start(fs_b),
        .line_start(ls_b), .de(de_b), .vio(vio_b.out)
    );

    logic [31:0] obs_a, obs_b;
    assign obs_a = {vio_a.hcount, vio_a.vcount, vio_a.hsync, vio_a.hblnk, vio_a.vsync, vio_a.vblnk,
                    de_a, fs_a, ls_a, rdy_a, err_a, pend_a};
    assign obs_b = {vio_b.hcount, vio_b.vcount, vio_b.hsync, vio_b.hblnk, vio_b.vsync, vio_b.vblnk,
                    de_b, fs_b, ls_b, rdy_b, err_b, pend_b};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare one prediction per clock, away from the edge.
    always @(posedge clk) begin
        #1;
        if (exp_a_q.size() > 0) check("bus_a", obs_a, exp_a_q.pop_front());
        if (exp_b_q.size() > 0) check("bus_b", obs_b, exp_b_q.pop_front());
    end

    // Driver: inputs are already set at a negedge; predict, push, move on.
    task automatic step();
        ma = mdl_next(ma, rst, pix_en, cfg_valid_a, cfg_in_a);
        mb = mdl_next(mb, rst, pix_en, cfg_valid_b, cfg_in_b);
        exp_a_q.push_back(mdl_out(ma));
        exp_b_q.push_back(mdl_out(mb));
        @(negedge clk);
        cfg_valid_a = 1'b0;
        cfg_valid_b = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int last_fs;
        int gap;
        int h_now;
        bit found;

        cfg_b0  = mk_cfg(8, 2, 3, 2, 4, 1, 2, 1);     // 15 x 8  = 120 cycles
        cfg_b1  = mk_cfg(6, 1, 2, 3, 3, 1, 1, 2);     // 12 x 7  = 84 cycles
        cfg_b2  = mk_cfg(5, 1, 1, 1, 3, 1, 1, 1);     // 8 x 6   = 48 cycles
        cfg_640 = mk_cfg(640, 16, 96, 48, 480, 10, 2, 33);
        bad1    = mk_cfg(8, 2, 0, 2, 4, 1, 2, 1);     // zero sync width
        bad2    = mk_cfg(2040, 16, 96, 48, 480, 10, 2, 33); // H_TOT 2200

        rst = 1'b1; pix_en = 1'b0;
        cfg_valid_a = 1'b0; cfg_valid_b = 1'b0;
        cfg_in_a = VGA_CFG_800x600; cfg_in_b = cfg_b0;
        ma = mdl_init(VGA_CFG_800x600, 1'b1, 1'b1);
        mb = mdl_init(cfg_b0, 1'b0, 1'b0);
        @(negedge clk);
        repeat (3) step();

        check("rst_hcount_a", 32'(vio_a.hcount), 0);
        check("rst_hsync_a", 32'(vio_a.hsync), 0);
        check("rst_hsync_b", 32'(vio_b.hsync), 1);
        check("rst_vsync_b", 32'(vio_b.vsync), 1);
        check("rst_de_a", 32'(de_a), 1);
        check("rst_ready_a", 32'(rdy_a), 1);

        // Free run: line timing on a, bad then good requests on b, 640x480 on a.
        rst = 1'b0; pix_en = 1'b1;
        last_fs = -1;
        for (int n = 0; n < 1100; n++) begin
            if (n == 20)  begin cfg_in_b = bad1;    cfg_valid_b = 1'b1; end
            if (n == 40)  begin cfg_in_b = bad2;    cfg_valid_b = 1'b1; end
            if (n == 60)  begin cfg_in_b = cfg_b1;  cfg_valid_b = 1'b1; end
            if (n == 62)  begin cfg_in_b = cfg_b2;  cfg_valid_b = 1'b1; end
            if (n == 300) begin cfg_in_a = cfg_640; cfg_valid_a = 1'b1; end
            step();
            h_now = (n + 1) % 1056;
            if (h_now == 839 || h_now == 968) check("a_hs_off", 32'(vio_a.hsync), 0);
            if (h_now == 840 || h_now == 967) check("a_hs_on", 32'(vio_a.hsync), 1);
            if (h_now == 1055) check("a_hblnk_end", 32'(vio_a.hblnk), 1);
            if (n + 1 == 1056) begin
                check("a_wrap_h", 32'(vio_a.hcount), 0);
                check("a_wrap_v", 32'(vio_a.vcount), 1);
                check("a_wrap_ls", 32'(ls_a), 1);
            end
            if (n == 20 || n == 40) check("b_err_pulse", 32'(err_b), 1);
            if (n == 21 || n == 41) check("b_err_clear", 32'(err_b), 0);
            if (n == 60) check("b_pend_set", 32'(pend_b), 1);
            if (n == 62) check("b_ignored_err", 32'(err_b), 0);
            if (n == 300) check("a_ready_low", 32'(rdy_a), 0);
            if (n > 60 && fs_b) begin
                if (last_fs >= 0) check("b_len_b1", 32'(n - last_fs), 84);
                else begin
                    check("b_apply_pend", 32'(pend_b), 0);
                    check("b_apply_ready", 32'(rdy_b), 1);
                end
                last_fs = n;
            end
        end
        check("a_still_pending", 32'(pend_a), 1);

        // pix_en gating: fixed 1,0,0,1 pattern, then random.
        for (int n = 0; n < 40; n++) begin
            pix_en = (n % 4 == 0 || n % 4 == 3);
            step();
        end
        for (int n = 0; n < 200; n++) begin
            pix_en = 1'($urandom_range(0, 1));
            step();
        end

        // Request landing exactly on the wrap edge must wait a full frame.
        pix_en = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            if (!mb.pending && mb.h == tot_h(mb.cur) - 1 && mb.v == tot_v(mb.cur) - 1) found = 1'b1;
            else step();
        end
        check("b_wrap_found", 32'(found), 1);
        cfg_in_b = cfg_b0; cfg_valid_b = 1'b1;
        step();
        check("b_wrap_fs", 32'(fs_b), 1);
        check("b_wrap_pend", 32'(pend_b), 1);
        gap = -1;
        for (int n = 1; n <= 130 && gap < 0; n++) begin
            step();
            if (fs_b) gap = n;
        end
        check("b_len_old_mode", 32'(gap), 84);
        gap = -1;
        for (int n = 1; n <= 130 && gap < 0; n++) begin
            step();
            if (fs_b) gap = n;
        end
        check("b_len_new_mode", 32'(gap), 120);

        // Reset while both generators hold a pending request.
        cfg_in_b = cfg_b1; cfg_valid_b = 1'b1;
        step();
        check("b_pend_pre_rst", 32'(pend_b), 1);
        repeat (5) step();
        rst = 1'b1;
        step();
        check("rst2_pend_a", 32'(pend_a), 0);
        check("rst2_pend_b", 32'(pend_b), 0);
        check("rst2_ready_b", 32'(rdy_b), 1);
        check("rst2_hcount_a", 32'(vio_a.hcount), 0);
        check("rst2_fs_b", 32'(fs_b), 0);
        step();
        rst = 1'b0;
        last_fs = 0;
        for (int n = 1; n <= 1100; n++) begin
            step();
            if (n == 1056) begin
                check("a_rst_wrap_h", 32'(vio_a.hcount), 0);
                check("a_rst_wrap_v", 32'(vio_a.vcount), 1);
            end
            if (fs_b) begin
                check("b_len_default", 32'(n - last_fs), 120);
                last_fs = n;
            end
        end

        check("queue_drained", 32'(exp_a_q.size() + exp_b_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_cfg.md
# vga_timing_cfg

Runtime-reconfigurable VGA timing generator, the parametrised successor of the fixed-mode timing controller. It produces `hcount`/`vcount`, sync and blanking on a `vga_if` bus, plus frame/line strobes and a data-enable. Mode changes are accepted at any time and applied only on a frame boundary. It sits at the head of the video pipeline and feeds all draw stages.

## Interface
- `CNT_W`, 11: counter and config field width; must match `vga_if` count width.
- `H_POL`, 1: hsync active level (1 = active-high).
- `V_POL`, 1: vsync active level.
- `DEF_CFG`, `VGA_CFG_800x600` (`vga_pkg`): mode loaded at reset. Horizontal: active 800, front porch 40, sync 128, back porch 88. Vertical: active 600, front porch 1, sync 4, back porch 23.
- `clk`  in  1  pixel-domain clock.
- `rst`  in  1  synchronous, active-high reset.
- `pix_en`  in  1  advance enable; counters step only when high.
- `cfg_in`  in  `vga_cfg_t`  requested mode. Fields `h_act`, `h_fp`, `h_sync`, `h_bp`, `v_act`, `v_fp`, `v_sync`, `v_bp`; each CNT_W bits.
- `cfg_valid`  in  1  request strobe.
- `cfg_ready`  out  1  high when no update is pending.
- `cfg_err`  out  1  one-cycle pulse: request rejected.
- `cfg_pending`  out  1  accepted mode waiting for frame boundary.
- `frame_start`  out  1  one-cycle pulse with (0,0) on the bus after a wrap.
- `line_start`  out  1  one-cycle pulse with `hcount==0` after a line wrap.
- `de`  out  1  `!hblnk && !vblnk`, registered with the bus.
- `vio`  `vga_if.out`  —  `hcount`, `vcount`, `hsync`, `hblnk`, `vsync`, `vblnk`.

## Operation
- Active mode register `cur`. Derived: `H_TOT = h_act+h_fp+h_sync+h_bp`, `HS_STR = h_act+h_fp`, `HS_STP = HS_STR+h_sync`. Vertical values are derived the same way.
- Sums are computed at CNT_W+2 bits.
- Counting happens on a `pix_en` cycle:
  - If `hcount==H_TOT-1`, `hcount` goes to 0 and `vcount` increments.
  - `vcount` wraps to 0 at `V_TOT-1` on the last pixel of the line.
- Decode uses the next count, so flags align with the registered count:
  - `hblnk = hcount >= h_act`.
  - `hsync` is active for `HS_STR <= hcount < HS_STP`, inactive otherwise.
  - Vertical flags decode the same way.
- Config handshake: a request is taken when `cfg_valid && cfg_ready`.
  - Validation: every field ≥1, `H_TOT ≤ 2^CNT_W`, `V_TOT ≤ 2^CNT_W`.
  - Valid request: stored in `pend`, `cfg_pending`=1, `cfg_ready`=0.
  - Invalid request: `cfg_err` pulses, `pend` is untouched.
  - `cfg_valid` while `cfg_ready`=0 is ignored; no error.
- Apply: on a `pix_en` cycle at the global wrap (last pixel of last line), `cur<=pend` and `cfg_pending` clears. The new frame starts at (0,0) with the new mode.
- A request accepted in the same cycle as the wrap applies at the next wrap, not the current one.

## Timing
- Reset values:
  - `hcount`=`vcount`=0; `hblnk`=`vblnk`=0.
  - `hsync`=`!H_POL`, `vsync`=`!V_POL`.
  - `de`=1.
  - `frame_start`=`line_start`=`cfg_err`=`cfg_pending`=0; `cfg_ready`=1.
  - `cur`=`DEF_CFG`.
- Reset mid-operation: all of the above within one cycle; a pending request is discarded.
- Latency: all `vio` signals, `de` and the strobes are registered. The value depends on the count one clock earlier plus one step when `pix_en`=1.
- `pix_en`=0: every output holds, strobes are low, and a wrap does not apply `pend`.
- No `frame_start` on leaving reset; the first pulse comes at the first wrap.
- `cfg_err` is asserted the cycle after the offending `cfg_valid`.
- `cfg_ready` falls the cycle after acceptance and rises the cycle after apply.

## Structure
- `vga_pkg` gets:
  - `typedef struct packed vga_cfg_t` (eight CNT_W fields).
  - `VGA_CFG_800x600` constant.
  - `function vga_cfg_check(vga_cfg_t) -> bit` for validation.
  - Existing fixed constants stay in place for legacy users.
- Sub-module `vga_cfg_shadow`: owns `pend`/`cur`, handshake, validation and apply-on-wrap. The top owns counters and decode.

## Test plan
- Reset, then free run in default mode, all `pix_en`=1:
  - `hcount` wraps 1055->0.
  - `hsync` is high exactly for `hcount` 840..967.
  - `vsync` is high for `vcount` 601..604.
  - `frame_start` every 1056*628 cycles.
- `pix_en` toggling 1,0,0,1: counts advance only on high cycles and outputs are frozen otherwise.
- Mode switch to 640x480 (16/96/48, 10/2/33) issued mid-frame:
  - `cfg_pending`=1 until the 800x600 wrap.
  - Next frame has `H_TOT`=800, `V_TOT`=525.
  - `cfg_ready` returns to 1.
- Invalid requests: `h_sync`=0, then `h_act`=2040 with `CNT_W`=11 (total >2048). Each gives a `cfg_err` pulse and the mode is unchanged.
- Second `cfg_valid` while pending: ignored, no `cfg_err`, and the first mode is applied.
- `rst` asserted with an update pending: outputs return to their reset values, `cfg_pending`=0, and the default mode resumes.
- Parameter case `H_POL`=`V_POL`=0: syncs idle high and pulse low in the same windows.
